// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; mdu_hilo is the slave.
interface mdu_hilo_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    modport master (
        output Start, MDUOp, A, B,
        input  Busy, HI, LO, Result
    );

    modport slave (
        input  Start, MDUOp, A, B,
        output Busy, HI, LO, Result
    );
endinterface

// File: rtl/mdu_hilo.sv
// MIPS multiply/divide unit: computes a full result at issue, holds it in shadow registers,
// and commits it to HI/LO after a fixed busy latency.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    mdu_hilo_if.slave   bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [3:0]  counter_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] shadow_hi_reg;
    logic [31:0] shadow_lo_reg;
    logic        commit_reg;

    logic [8:1]  op_hot;
    logic        busy;
    logic        accept;

    genvar gi;
    generate
        for (gi = 1; gi <= 8; gi++) begin : g_op_decode
            assign op_hot[gi] = (bus.MDUOp == 4'(gi));
        end
    endgenerate

    assign busy   = (counter_reg != 4'd0);
    assign accept = bus.Start && !busy;

    // Multiply: sign-extend for MULT, zero-extend for MULTU, keep the low 64 bits.
    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign mul_signed = op_hot[OP_MULT];
    assign a_ext      = {{32{mul_signed & bus.A[31]}}, bus.A};
    assign b_ext      = {{32{mul_signed & bus.B[31]}}, bus.B};
    assign product    = a_ext * b_ext;

    // Divide on magnitudes so the 0x80000000 / -1 case wraps cleanly instead of overflowing.
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign div_signed = op_hot[OP_DIV];
    assign a_mag      = (div_signed && bus.A[31]) ? -bus.A : bus.A;
    assign b_mag      = (div_signed && bus.B[31]) ? -bus.B : bus.B;
    assign b_div      = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_div;
    assign r_mag      = a_mag % b_div;
    assign quotient   = (div_signed && (bus.A[31] ^ bus.B[31])) ? -q_mag : q_mag;
    assign remainder  = (div_signed && bus.A[31]) ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg   <= 4'd0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            shadow_hi_reg <= 32'd0;
            shadow_lo_reg <= 32'd0;
            commit_reg    <= 1'b0;
        end else if (busy) begin
            counter_reg <= counter_reg - 4'd1;
            if (counter_reg == 4'd1 && commit_reg) begin
                hi_reg <= shadow_hi_reg;
                lo_reg <= shadow_lo_reg;
            end
        end else if (accept) begin
            if (op_hot[OP_MULT] || op_hot[OP_MULTU]) begin
                shadow_hi_reg <= product[63:32];
                shadow_lo_reg <= product[31:0];
                commit_reg    <= 1'b1;
                counter_reg   <= 4'(MULT_CYCLES);
            end else if (op_hot[OP_DIV] || op_hot[OP_DIVU]) begin
                shadow_hi_reg <= remainder;
                shadow_lo_reg <= quotient;
                // A zero divisor still occupies the unit but must leave HI/LO untouched.
                commit_reg    <= (bus.B != 32'd0);
                counter_reg   <= 4'(DIV_CYCLES);
            end else if (op_hot[OP_MTHI]) begin
                hi_reg <= bus.A;
            end else if (op_hot[OP_MTLO]) begin
                lo_reg <= bus.A;
            end
        end
    end

    assign bus.Busy   = busy;
    assign bus.HI     = hi_reg;
    assign bus.LO     = lo_reg;
    assign bus.Result = op_hot[OP_MFHI] ? hi_reg :
                        op_hot[OP_MFLO] ? lo_reg : 32'd0;
endmodule
